// File: rtl/video_timing_reader_if.sv
// Frame-buffer read bus between the video timing reader and the frame-read controller.
// The master drives the frame request and the per-pixel read strobe.
interface video_timing_reader_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic                  read_req;
    logic                  read_req_ack;
    logic                  read_en;
    logic                  read_empty;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output read_req,
        output read_en,
        input  read_req_ack,
        input  read_empty,
        input  read_data
    );

    modport slave (
        input  read_req,
        input  read_en,
        output read_req_ack,
        output read_empty,
        output read_data
    );
endinterface

// File: rtl/video_timing_reader.sv
// Video timing generator with frame-buffer read front end.
// Raw timing is delayed RD_LATENCY+1 cycles so sync/de/coordinates line up with returned pixels.
module video_timing_reader #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    H_ACTIVE   = 480,
    parameter int                    H_FP       = 8,
    parameter int                    H_SYNC     = 4,
    parameter int                    H_BP       = 43,
    parameter int                    V_ACTIVE   = 272,
    parameter int                    V_FP       = 8,
    parameter int                    V_SYNC     = 4,
    parameter int                    V_BP       = 12,
    parameter bit                    HS_POL     = 1'b0,
    parameter bit                    VS_POL     = 1'b0,
    parameter int                    RD_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] FILL_COLOR = '0
) (
    input  logic                   video_clk,
    input  logic                   rst_n,
    video_timing_reader_if.master  rd,
    output logic                   hs,
    output logic                   vs,
    output logic                   de,
    output logic [DATA_WIDTH-1:0]  vout_data,
    output logic [11:0]            active_x,
    output logic [11:0]            active_y,
    output logic                   frame_start,
    output logic                   underflow
);
    localparam int          L        = RD_LATENCY + 1;
    localparam logic [11:0] H_TOTAL  = 12'(H_SYNC + H_BP + H_ACTIVE + H_FP);
    localparam logic [11:0] V_TOTAL  = 12'(V_SYNC + V_BP + V_ACTIVE + V_FP);
    localparam logic [11:0] H_SYNC_W = 12'(H_SYNC);
    localparam logic [11:0] V_SYNC_W = 12'(V_SYNC);
    localparam logic [11:0] H_DE_BEG = 12'(H_SYNC + H_BP);
    localparam logic [11:0] H_DE_END = 12'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [11:0] V_DE_BEG = 12'(V_SYNC + V_BP);
    localparam logic [11:0] V_DE_END = 12'(V_SYNC + V_BP + V_ACTIVE);

    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic        raw_hs, raw_vs, raw_de, raw_fs, req_set;
    logic [11:0] raw_x, raw_y;

    logic [L-1:0]          hs_p_q, hs_p_d, vs_p_q, vs_p_d;
    logic [L-1:0]          de_p_q, de_p_d, fs_p_q, fs_p_d;
    logic [L-1:0][11:0]    x_p_q, x_p_d, y_p_q, y_p_d;
    logic [RD_LATENCY-1:0] emp_p_q, emp_p_d;
    logic [DATA_WIDTH-1:0] vout_q, vout_d;
    logic                  read_req_q, read_req_d;
    logic                  underflow_q, underflow_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_TOTAL - 12'd1) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_TOTAL - 12'd1) ? 12'd0 : v_cnt_q + 12'd1;
        end
    end

    always_comb begin
        raw_hs  = (h_cnt_q < H_SYNC_W) ? HS_POL : ~HS_POL;
        raw_vs  = (v_cnt_q < V_SYNC_W) ? VS_POL : ~VS_POL;
        raw_de  = (h_cnt_q >= H_DE_BEG) && (h_cnt_q < H_DE_END) &&
                  (v_cnt_q >= V_DE_BEG) && (v_cnt_q < V_DE_END);
        raw_x   = raw_de ? h_cnt_q - H_DE_BEG : 12'd0;
        raw_y   = raw_de ? v_cnt_q - V_DE_BEG : 12'd0;
        raw_fs  = raw_de && (raw_x == 12'd0) && (raw_y == 12'd0);
        // One request per frame, raised as the vertical sync interval ends
        req_set = (v_cnt_q == V_SYNC_W) && (h_cnt_q == 12'd0);
    end

    always_comb begin
        hs_p_d      = hs_p_q;
        vs_p_d      = vs_p_q;
        de_p_d      = de_p_q;
        fs_p_d      = fs_p_q;
        x_p_d       = x_p_q;
        y_p_d       = y_p_q;
        emp_p_d     = emp_p_q;
        hs_p_d[0]   = raw_hs;
        vs_p_d[0]   = raw_vs;
        de_p_d[0]   = raw_de;
        fs_p_d[0]   = raw_fs;
        x_p_d[0]    = raw_x;
        y_p_d[0]    = raw_y;
        emp_p_d[0]  = raw_de & rd.read_empty;
        for (int i = 1; i < L; i++) begin
            hs_p_d[i] = hs_p_q[i-1];
            vs_p_d[i] = vs_p_q[i-1];
            de_p_d[i] = de_p_q[i-1];
            fs_p_d[i] = fs_p_q[i-1];
            x_p_d[i]  = x_p_q[i-1];
            y_p_d[i]  = y_p_q[i-1];
        end
        for (int i = 1; i < RD_LATENCY; i++) begin
            emp_p_d[i] = emp_p_q[i-1];
        end

        // Stage L-2 describes the pixel whose read_data is on the bus right now
        if (!de_p_q[L-2]) begin
            vout_d = '0;
        end else if (emp_p_q[RD_LATENCY-1]) begin
            vout_d = FILL_COLOR;
        end else begin
            vout_d = rd.read_data;
        end

        read_req_d  = req_set | (read_req_q & ~rd.read_req_ack);
        // Clears together with the visible frame_start pulse; a new set wins
        underflow_d = (raw_de & rd.read_empty) | (underflow_q & ~fs_p_q[L-2]);
    end

    always_ff @(posedge video_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q     <= '0;
            v_cnt_q     <= '0;
            hs_p_q      <= {L{~HS_POL}};
            vs_p_q      <= {L{~VS_POL}};
            de_p_q      <= '0;
            fs_p_q      <= '0;
            x_p_q       <= '0;
            y_p_q       <= '0;
            emp_p_q     <= '0;
            vout_q      <= '0;
            read_req_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            h_cnt_q     <= h_cnt_d;
            v_cnt_q     <= v_cnt_d;
            hs_p_q      <= hs_p_d;
            vs_p_q      <= vs_p_d;
            de_p_q      <= de_p_d;
            fs_p_q      <= fs_p_d;
            x_p_q       <= x_p_d;
            y_p_q       <= y_p_d;
            emp_p_q     <= emp_p_d;
            vout_q      <= vout_d;
            read_req_q  <= read_req_d;
            underflow_q <= underflow_d;
        end
    end

    assign rd.read_en   = raw_de;
    assign rd.read_req  = read_req_q;
    assign hs           = hs_p_q[L-1];
    assign vs           = vs_p_q[L-1];
    assign de           = de_p_q[L-1];
    assign frame_start  = fs_p_q[L-1];
    assign active_x     = x_p_q[L-1];
    assign active_y     = y_p_q[L-1];
    assign vout_data    = vout_q;
    assign underflow    = underflow_q;
endmodule

// File: tb/tb_video_timing_reader.sv
// Bench for video_timing_reader: four configurations (RD_LATENCY 1..4, mixed sync polarity)
// share one stimulus and are compared against a frame-time reference model.
module tb_video_timing_reader;
    localparam int          HT   = 14;   // 2 sync + 2 bp + 8 active + 2 fp
    localparam int          VT   = 7;    // 1 sync + 1 bp + 4 active + 1 fp
    localparam int          HB   = 4;
    localparam int          HA   = 8;
    localparam int          VB   = 2;
    localparam int          VA   = 4;
    localparam logic [15:0] FILL = 16'hF00D;

    logic clk = 1'b0;
    logic rst_n;
    logic ack;
    logic empty;
    logic [3:0][15:0] rdata;

    logic [3:0]        hs_o, vs_o, de_o, fs_o, uf_o, ren_o, req_o;
    logic [3:0][15:0]  vout_o;
    logic [3:0][11:0]  ax_o, ay_o;

    int tests  = 0;
    int failed = 0;
    int k      = 0;
    bit req_m;
    bit [3:0] uf_m;
    bit empty_hist [0:1023];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : cfg
        localparam int LAT = g + 1;
        localparam bit POL = (g != 1);
        video_timing_reader_if #(.DATA_WIDTH(16)) bus ();
        assign bus.read_req_ack = ack;
        assign bus.read_empty   = empty;
        assign bus.read_data    = rdata[g];
        assign req_o[g]         = bus.read_req;
        assign ren_o[g]         = bus.read_en;
        video_timing_reader #(
            .DATA_WIDTH(16), .H_ACTIVE(HA), .H_FP(2), .H_SYNC(2), .H_BP(2),
            .V_ACTIVE(VA), .V_FP(1), .V_SYNC(1), .V_BP(1),
            .HS_POL(POL), .VS_POL(POL), .RD_LATENCY(LAT), .FILL_COLOR(FILL)
        ) dut (
            .video_clk(clk), .rst_n(rst_n), .rd(bus),
            .hs(hs_o[g]), .vs(vs_o[g]), .de(de_o[g]), .vout_data(vout_o[g]),
            .active_x(ax_o[g]), .active_y(ay_o[g]),
            .frame_start(fs_o[g]), .underflow(uf_o[g])
        );
    end

    function automatic int raw_h(int t); return t % HT; endfunction
    function automatic int raw_v(int t); return (t / HT) % VT; endfunction
    function automatic bit raw_de(int t);
        return t >= 0 && raw_h(t) >= HB && raw_h(t) < HB + HA && raw_v(t) >= VB && raw_v(t) < VB + VA;
    endfunction
    function automatic logic [15:0] pattern(int t);
        return {8'(raw_v(t) - VB), 8'(raw_h(t) - HB)};
    endfunction
    function automatic bit exp_fs(int g, int t);
        int s = t - (g + 2);
        return raw_de(s) && raw_h(s) == HB && raw_v(s) == VB;
    endfunction

    task automatic check(input string tag, input int g, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s cfg%0d k=%0d observed %0h expected %0h", tag, g, k, obs, exp);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < 4; g++) begin
            int  s   = k - (g + 2);
            bit  pol = (g != 1);
            bit  e_de = raw_de(s);
            logic [31:0] e_x = e_de ? 32'(raw_h(s) - HB) : 32'd0;
            logic [31:0] e_y = e_de ? 32'(raw_v(s) - VB) : 32'd0;
            logic [15:0] e_vout = !e_de ? 16'd0 : (empty_hist[s] ? FILL : pattern(s));
            bit  e_hs = (s >= 0 && raw_h(s) < 2) ? pol : ~pol;
            bit  e_vs = (s >= 0 && raw_v(s) < 1) ? pol : ~pol;
            check("hs", g, 32'(hs_o[g]), 32'(e_hs));
            check("vs", g, 32'(vs_o[g]), 32'(e_vs));
            check("de", g, 32'(de_o[g]), 32'(e_de));
            check("active_x", g, 32'(ax_o[g]), e_x);
            check("active_y", g, 32'(ay_o[g]), e_y);
            check("vout_data", g, 32'(vout_o[g]), 32'(e_vout));
            check("frame_start", g, 32'(fs_o[g]), 32'(exp_fs(g, k)));
            check("underflow", g, 32'(uf_o[g]), 32'(uf_m[g]));
            check("read_en", g, 32'(ren_o[g]), 32'(raw_de(k)));
            check("read_req", g, 32'(req_o[g]), 32'(req_m));
        end
    endtask

    task automatic drive(input int mode);
        if (mode == 1) begin
            ack   = (k == 20 || k == 118 || k == 210 || k == 300);
            empty = (k == 146);   // pixel (x=2, y=1) of frame 1
        end else begin
            ack   = ($urandom_range(0, 5) == 0);
            empty = ($urandom_range(0, 15) == 0);
        end
        empty_hist[k] = empty;
        for (int g = 0; g < 4; g++) begin
            int s = k - (g + 1);
            rdata[g] = raw_de(s) ? pattern(s) : 16'($urandom);
        end
    endtask

    task automatic update_model();
        bit set_ev = (raw_v(k) == 1) && (raw_h(k) == 0);
        req_m = set_ev | (req_m & ~ack);
        for (int g = 0; g < 4; g++)
            uf_m[g] = (raw_de(k) & empty) | (uf_m[g] & ~exp_fs(g, k + 1));
    endtask

    task automatic run_cycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            drive(mode);
            @(negedge clk);
            check_all();
            update_model();
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ack   = 1'b0;
        empty = 1'b0;
        rdata = '0;
        req_m = 1'b0;
        uf_m  = '0;
        foreach (empty_hist[i]) empty_hist[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Three-plus frames of directed handshakes and one underflow pixel
        run_cycles(342, 1);

        // Asynchronous reset mid-line at h=6, v=3
        rst_n = 1'b0;
        #1;
        k     = 0;
        req_m = 1'b0;
        uf_m  = '0;
        ack   = 1'b0;
        empty = 1'b0;
        foreach (empty_hist[i]) empty_hist[i] = 1'b0;
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        rst_n = 1'b1;

        // Four frames of randomized acks, FIFO-empty events and off-screen bus data
        run_cycles(400, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
